// File: rtl/grain_buffer_loader_pkg.sv
// grain_buffer_loader_pkg
// Shared encodings for the grain buffer loader:
//   - loader FSM states (state_e)
//   - write modes FULL=0 / HALF=1 / BYTE=2 (mode_e)
//   - top-controller state codes idle / inputB_start / channel_switch
//   - default row-index width of each byte bank (RAM_ADDR_WIDTH)
//   - helpers: mode decode at start, row-part data selection
package grain_buffer_loader_pkg;

  localparam int RAM_ADDR_WIDTH = 6;

  localparam logic [3:0] CS_IDLE           = 4'd0;
  localparam logic [3:0] CS_INPUTB_START   = 4'd1;
  localparam logic [3:0] CS_CHANNEL_SWITCH = 4'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_FULL = 2'd0,
    MODE_HALF = 2'd1,
    MODE_BYTE = 2'd2
  } mode_e;

  // Idle controller loads whole words; pooling or inputB loads halves;
  // everything else (channel switch etc.) loads single bytes.
  function automatic mode_e mode_of(logic [3:0] cs, logic pool);
    mode_e m;
    if (cs == CS_IDLE)                         m = MODE_FULL;
    else if (pool || (cs == CS_INPUTB_START))  m = MODE_HALF;
    else                                       m = MODE_BYTE;
    return m;
  endfunction

  // Zero-extended row-part of a source word for sub-write s.
  function automatic logic [31:0] pick_part(mode_e m, logic [31:0] w, logic [1:0] s);
    logic [31:0] r;
    logic [7:0]  b;
    case (s)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    case (m)
      MODE_FULL: r = w;
      MODE_HALF: r = s[0] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
      default:   r = {24'h0, b};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/grain_buffer_loader_if.sv
// grain_buffer_loader_if
// Source-stream and buffer-write signals of the grain buffer loader.
//   in_valid/in_data/in_ready : 32-bit source word handshake
//   we/a/d                    : buffer write port (address InBuAddrWidth bits)
// modport master : loader side (drives in_ready, we, a, d)
// modport slave  : environment side (drives in_valid, in_data)
interface grain_buffer_loader_if #(
  parameter int InBuAddrWidth = 8
);
  logic                     in_valid;
  logic [31:0]              in_data;
  logic                     in_ready;
  logic                     we;
  logic [InBuAddrWidth-1:0] a;
  logic [31:0]              d;

  modport master (input in_valid, in_data, output in_ready, we, a, d);
  modport slave  (output in_valid, in_data, input in_ready, we, a, d);
endinterface

// File: rtl/grain_wr_addr_gen.sv
// grain_wr_addr_gen
// Row/sub-index counter and buffer address formatter.
//   clr      : restart at row 0, sub 0
//   step     : advance to the next sub-write (next row after the last sub)
//   mode     : latched write mode (sub-writes per row: 1/2/4)
//   rows_m1  : latched last row index
//   sub      : sub-write index of the next write
//   addr     : zero-extended address of the next write
//   last_sub : next write is the last part of its row
//   last_row : current row is the final row
module grain_wr_addr_gen
  import grain_buffer_loader_pkg::*;
#(
  parameter int InBuAddrWidth = 8,
  parameter int ROW_W         = RAM_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     step,
  input  mode_e                    mode,
  input  logic [ROW_W-1:0]         rows_m1,
  output logic [1:0]               sub,
  output logic [InBuAddrWidth-1:0] addr,
  output logic                     last_sub,
  output logic                     last_row
);

  logic [ROW_W-1:0] row_q;
  logic [1:0]       sub_q;
  logic [ROW_W+1:0] raw;

  always_comb begin
    last_sub = 1'b0;
    raw      = '0;
    case (mode)
      MODE_FULL: begin
        last_sub = 1'b1;
        raw      = {2'b00, row_q};
      end
      MODE_HALF: begin
        last_sub = sub_q[0];
        raw      = {1'b0, row_q, sub_q[0]};
      end
      default: begin
        last_sub = (sub_q == 2'd3);
        raw      = {row_q, sub_q};
      end
    endcase
  end

  assign last_row = (row_q == rows_m1);
  assign sub      = sub_q;
  assign addr     = InBuAddrWidth'(raw);

  // The row counter holds on the final row so a maximal rows_m1 never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      sub_q <= '0;
    end else if (clr) begin
      row_q <= '0;
      sub_q <= '0;
    end else if (step) begin
      if (last_sub) begin
        sub_q <= '0;
        if (!last_row) row_q <= row_q + 1'b1;
      end else begin
        sub_q <= sub_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/grain_buffer_loader.sv
// grain_buffer_loader
// Loads 32-bit source words into the grain buffer as whole words (FULL),
// 16-bit halves (HALF) or single bytes (BYTE), one row-part per cycle.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   start                          : one-cycle load request (idle only)
//   current_state, poolingen_op    : mode selection, latched at start
//   rows_m1                        : rows to load minus 1, latched at start
//   bus (grain_buffer_loader_if)   : in_valid/in_data/in_ready, we/a/d
//   busy, done, err                : status; err is sticky until next start
// Build option: GRAIN_LOADER_BYTE_MODE_EN enables BYTE mode; without it a
// BYTE-mode start reports err and finishes immediately with no writes.
module grain_buffer_loader
  import grain_buffer_loader_pkg::*;
#(
  parameter int InBuAddrWidth = 8,
  parameter int ROW_W         = RAM_ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           current_state,
  input  logic                 poolingen_op,
  input  logic [ROW_W-1:0]     rows_m1,
  grain_buffer_loader_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e                   state;
  mode_e                    mode_q;
  mode_e                    start_mode;
  logic [ROW_W-1:0]         rows_m1_q;
  logic [31:0]              word_q;
  logic                     in_ready_q;
  logic                     we_q;
  logic [InBuAddrWidth-1:0] a_q;
  logic [31:0]              d_q;
  logic                     wr_last_sub_q;
  logic                     wr_last_row_q;
  logic                     start_unsup;
  logic                     xfer;
  logic                     clr;
  logic                     step;
  logic [1:0]               sub;
  logic [InBuAddrWidth-1:0] nxt_addr;
  logic                     last_sub;
  logic                     last_row;

  assign start_mode = mode_of(current_state, poolingen_op);

`ifdef GRAIN_LOADER_BYTE_MODE_EN
  assign start_unsup = 1'b0;
`else
  assign start_unsup = (start_mode == MODE_BYTE);
`endif

  assign xfer = (state == S_FETCH) && in_ready_q && bus.in_valid;
  assign clr  = (state == S_IDLE) && start;
  // The counter always points at the next write to issue; it steps whenever
  // a write is loaded into the output registers.
  assign step = xfer || ((state == S_WRITE) && !wr_last_sub_q);

  grain_wr_addr_gen #(
    .InBuAddrWidth (InBuAddrWidth),
    .ROW_W         (ROW_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .step     (step),
    .mode     (mode_q),
    .rows_m1  (rows_m1_q),
    .sub      (sub),
    .addr     (nxt_addr),
    .last_sub (last_sub),
    .last_row (last_row)
  );

  // Outputs are registered one write ahead; the position flags of the write
  // on the outputs travel with it so S_WRITE knows when the row is finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      mode_q        <= MODE_FULL;
      rows_m1_q     <= '0;
      word_q        <= '0;
      in_ready_q    <= 1'b0;
      we_q          <= 1'b0;
      a_q           <= '0;
      d_q           <= '0;
      wr_last_sub_q <= 1'b0;
      wr_last_row_q <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q    <= start_mode;
            rows_m1_q <= rows_m1;
            if (start_unsup) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              err        <= 1'b0;
              busy       <= 1'b1;
              in_ready_q <= 1'b1;
              state      <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (xfer) begin
            word_q        <= bus.in_data;
            in_ready_q    <= 1'b0;
            we_q          <= 1'b1;
            a_q           <= nxt_addr;
            d_q           <= pick_part(mode_q, bus.in_data, sub);
            wr_last_sub_q <= last_sub;
            wr_last_row_q <= last_row;
            state         <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (wr_last_sub_q) begin
            we_q <= 1'b0;
            a_q  <= '0;
            d_q  <= '0;
            if (wr_last_row_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              in_ready_q <= 1'b1;
              state      <= S_FETCH;
            end
          end else begin
            we_q          <= 1'b1;
            a_q           <= nxt_addr;
            d_q           <= pick_part(mode_q, word_q, sub);
            wr_last_sub_q <= last_sub;
            wr_last_row_q <= last_row;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.we       = we_q;
  assign bus.a        = a_q;
  assign bus.d        = d_q;

endmodule

// File: tb/tb_grain_buffer_loader.sv
module tb_grain_buffer_loader;
  import grain_buffer_loader_pkg::*;

  logic                      clk;
  logic                      rst_n;
  logic                      start;
  logic [3:0]                cs;
  logic                      pool;
  logic [RAM_ADDR_WIDTH-1:0] rows;
  logic                      busy, done, err;

  grain_buffer_loader_if #(.InBuAddrWidth(8)) bus ();

  grain_buffer_loader #(
    .InBuAddrWidth (8),
    .ROW_W         (RAM_ADDR_WIDTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .current_state (cs),
    .poolingen_op  (pool),
    .rows_m1       (rows),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observation log
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  logic [31:0] ex_a[$];
  logic [31:0] ex_d[$];
  int n_done, first_we_cyc, last_we_cyc, done_cyc, rdy_cnt;
  int idle_nonzero = 0;
  int bad_busy = 0;
  int start_cyc;

  // source model
  logic [31:0] src_q[$];
  int gap_cfg = 0;
  int gap_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.we) begin
      if (log_a.size() == 0) first_we_cyc = cyc;
      last_we_cyc = cyc;
      log_a.push_back(32'(bus.a));
      log_d.push_back(bus.d);
    end else if (bus.a != '0 || bus.d != '0) begin
      idle_nonzero++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (bus.in_ready) rdy_cnt++;
    if ((bus.we && !busy) || (done && busy)) bad_busy++;
  end

  initial begin : source
    logic fire;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    forever begin
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        gap_cnt = gap_cfg;
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
      if (src_q.size() > 0 && gap_cnt == 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = src_q[0];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
      end
    end
  end

  task automatic clear_logs();
    log_a.delete(); log_d.delete(); ex_a.delete(); ex_d.delete();
    n_done = 0; first_we_cyc = -1; last_we_cyc = -1; done_cyc = -1; rdy_cnt = 0;
  endtask

  task automatic pulse_start(input logic [3:0] c, input logic p,
                             input logic [RAM_ADDR_WIDTH-1:0] r);
    @(posedge clk);
    #1;
    cs = c; pool = p; rows = r; start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (n_done == 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 32'(n_done != 0), 32'd1);
    repeat (6) @(negedge clk);
    check({tag, "_done_cnt"}, 32'(n_done), 32'd1);
  endtask

  task automatic wait_log(input string tag, input int n);
    int k;
    k = 0;
    while (log_a.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_log_reached"}, 32'(log_a.size() >= n), 32'd1);
  endtask

  task automatic expect_wr(input logic [31:0] ea, input logic [31:0] ed);
    ex_a.push_back(ea);
    ex_d.push_back(ed);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_wr_count"}, 32'(log_a.size()), 32'(ex_a.size()));
    for (int i = 0; i < ex_a.size() && i < log_a.size(); i++) begin
      check($sformatf("%s_a%0d", tag, i), log_a[i], ex_a[i]);
      check($sformatf("%s_d%0d", tag, i), log_d[i], ex_d[i]);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    rst_n = 1'b0; start = 1'b0; cs = '0; pool = 1'b0; rows = '0;
    clear_logs();
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_we",       32'(bus.we),       32'd0);
    check("rst_a",        32'(bus.a),        32'd0);
    check("rst_d",        bus.d,             32'd0);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_done",     32'(done),         32'd0);
    check("rst_err",      32'(err),          32'd0);
    rst_n = 1'b1;

    // FULL: 4 words back to back
    clear_logs();
    for (int n = 0; n < 4; n++) src_q.push_back(32'h44332211 + n);
    pulse_start(CS_IDLE, 1'b0, 6'd3);
    wait_done("full");
    expect_wr(0, 32'h44332211); expect_wr(1, 32'h44332212);
    expect_wr(2, 32'h44332213); expect_wr(3, 32'h44332214);
    check_log("full");
    check("full_tput", 32'(last_we_cyc - first_we_cyc), 32'd6);
    check("full_done_lat", 32'(done_cyc), 32'(last_we_cyc + 1));
    check("full_first_lat", 32'(first_we_cyc - start_cyc), 32'd2);
    check("full_err", 32'(err), 32'd0);

    // HALF via inputB_start
    clear_logs(); src_q.delete();
    src_q.push_back(32'hDDCCBBAA); src_q.push_back(32'h44332211);
    pulse_start(CS_INPUTB_START, 1'b0, 6'd1);
    wait_done("half");
    expect_wr(0, 32'h0000BBAA); expect_wr(1, 32'h0000DDCC);
    expect_wr(2, 32'h00002211); expect_wr(3, 32'h00004433);
    check_log("half");
    check("half_tput", 32'(last_we_cyc - first_we_cyc), 32'd4);
    check("half_done_lat", 32'(done_cyc), 32'(last_we_cyc + 1));

    // BYTE via channel_switch
    clear_logs(); src_q.delete();
    src_q.push_back(32'h04030201);
    pulse_start(CS_CHANNEL_SWITCH, 1'b0, 6'd0);
    wait_done("byte");
`ifdef GRAIN_LOADER_BYTE_MODE_EN
    expect_wr(0, 32'h1); expect_wr(1, 32'h2); expect_wr(2, 32'h3); expect_wr(3, 32'h4);
    check_log("byte");
    check("byte_err", 32'(err), 32'd0);
`else
    check_log("byte");
    check("byte_err", 32'(err), 32'd1);
    check("byte_done_lat", 32'(done_cyc), 32'(start_cyc + 1));
    check("byte_no_ready", 32'(rdy_cnt), 32'd0);
`endif

    // Backpressure: 5 idle cycles between words
    clear_logs(); src_q.delete(); gap_cfg = 5;
    src_q.push_back(32'h11111111); src_q.push_back(32'h22222222); src_q.push_back(32'h33333333);
    pulse_start(CS_IDLE, 1'b0, 6'd2);
    check("bp_err_cleared", 32'(err), 32'd0);
    wait_done("bp");
    expect_wr(0, 32'h11111111); expect_wr(1, 32'h22222222); expect_wr(2, 32'h33333333);
    check_log("bp");
    check("bp_spacing", 32'(last_we_cyc - first_we_cyc), 32'd12);
    gap_cfg = 0;

    // Reset during HALF row 1
    clear_logs(); src_q.delete();
    src_q.push_back(32'hDDCCBBAA); src_q.push_back(32'h44332211);
    pulse_start(CS_INPUTB_START, 1'b0, 6'd1);
    wait_log("rst_mid", 3);
    check("rst_mid_pre_a", log_a[2], 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_we",   32'(bus.we),       32'd0);
    check("rst_mid_a",    32'(bus.a),        32'd0);
    check("rst_mid_d",    bus.d,             32'd0);
    check("rst_mid_rdy",  32'(bus.in_ready), 32'd0);
    check("rst_mid_busy", 32'(busy),         32'd0);
    src_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_no_done", 32'(n_done), 32'd0);
    clear_logs();
    src_q.push_back(32'h12345678);
    pulse_start(CS_IDLE, 1'b0, 6'd0);
    wait_done("post_rst");
    expect_wr(0, 32'h12345678);
    check_log("post_rst");

    // Pooling HALF, then stray start and live input changes mid-load
    clear_logs(); src_q.delete();
    src_q.push_back(32'h87654321);
    pulse_start(CS_CHANNEL_SWITCH, 1'b1, 6'd0);
    wait_log("live", 1);
    start = 1'b1; pool = 1'b0; cs = CS_IDLE; rows = 6'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("live");
    expect_wr(0, 32'h00004321); expect_wr(1, 32'h00008765);
    check_log("live");

    check("idle_ad_zero", 32'(idle_nonzero), 32'd0);
    check("busy_consistency", 32'(bad_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grain_buffer_loader.md
GRAIN_BUFFER_LOADER -- requirements
Module: grain_buffer_loader

Interface
REQ-001 SHALL have parameter InBuAddrWidth, default 8, meaning the width of the buffer write address `a`.
REQ-002 SHALL have parameter ROW_W, default `ram_addr_width`, meaning the row-index width of each byte bank.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a load; sampled only in S_IDLE.
REQ-006 SHALL have port current_state, input, 4, the top controller state (0=idle, 1=inputB_start, 2=channel_switch); latched at start.
REQ-007 SHALL have port poolingen_op, input, 1, the pooling-enable flag; latched at start.
REQ-008 SHALL have port rows_m1, input, ROW_W, the number of rows to load minus 1; latched at start.
REQ-009 SHALL have port in_valid, input, 1, meaning the source word is valid.
REQ-010 SHALL have port in_data, input, 32, the source word; byte j is in_data[8j+7:8j].
REQ-011 SHALL have port in_ready, output, 1, meaning the loader accepts a word; a transfer occurs when in_valid && in_ready.
REQ-012 SHALL have port we, output, 1, the buffer write enable.
REQ-013 SHALL have port a, output, InBuAddrWidth, the buffer write address.
REQ-014 SHALL have port d, output, 32, the buffer write data.
REQ-015 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-016 SHALL have port done, output, 1, a one-cycle pulse after the last write.
REQ-017 SHALL have port err, output, 1, a sticky flag for an unsupported-mode start; cleared by the next accepted start.

Function
REQ-018 SHALL latch the mode at an accepted start: FULL if current_state==0; else HALF if poolingen_op==1 or current_state==1; else BYTE.
REQ-019 SHALL implement FSM states S_IDLE, S_FETCH, S_WRITE and S_DONE; S_IDLE goes to S_FETCH on start.
REQ-020 SHALL assert in_ready only in S_FETCH; a transfer captures in_data into a word register and moves the FSM to S_WRITE.
REQ-021 SHALL, in FULL mode, issue one write per word in S_WRITE: a=row, d=word.
REQ-022 SHALL, in HALF mode, issue two consecutive writes per word: a={row,1'b0} with d={16'h0,word[15:0]}, then a={row,1'b1} with d={16'h0,word[31:16]}.
REQ-023 SHALL, in BYTE mode, issue four consecutive writes per word: a={row,j[1:0]} for j=0..3 with d={24'h0,byte j}.
REQ-024 SHALL zero-extend `a` to InBuAddrWidth; `a` and `d` are don't-care-free and SHALL be 0 whenever we=0.
REQ-025 SHALL write one row-part per cycle, with the first write in the cycle after the transfer; after the last sub-write of a row, the FSM goes to S_FETCH, or to S_DONE when row==rows_m1.
REQ-026 SHALL hold S_DONE for exactly one cycle with done=1, then return to S_IDLE; busy=0 in S_DONE.
REQ-027 SHALL ignore start while not in S_IDLE; live changes of current_state, poolingen_op or rows_m1 during a load SHALL have no effect.
REQ-028 SHALL add no wait states while in_valid is held high: throughput is 1 word per 2/3/5 cycles in FULL/HALF/BYTE mode.
REQ-029 SHALL stall with in_ready=1 and we=0 in S_FETCH for as long as in_valid is low.
REQ-030 SHALL never wrap the row counter: rows_m1 at its maximum writes rows 0..2^ROW_W-1, then goes to done.

Reset
REQ-031 SHALL, on rst_n=0, immediately force S_IDLE, the row and sub counters to 0, and in_ready=we=busy=done=err=0, with a=0 and d=0.
REQ-032 SHALL abandon a load interrupted by reset with no done pulse; writes already issued remain in the buffer.

Configuration
REQ-033 SHALL, with GRAIN_LOADER_BYTE_MODE_EN defined, implement BYTE mode per REQ-023.
REQ-034 SHALL, without GRAIN_LOADER_BYTE_MODE_EN, answer a BYTE-mode start with err=1 and S_DONE on the next cycle, with no writes and no in_ready.

Structure
REQ-035 SHALL place the FSM state encodings, the mode encodings (FULL=0, HALF=1, BYTE=2) and the controller state codes idle/inputB_start/channel_switch in the shared define.v.
REQ-036 SHALL factor the row/sub-index counter and address formatter into a sub-module, grain_wr_addr_gen; the FSM and handshake remain in the top level.

Verification
REQ-037 SHALL cover FULL mode: current_state=0, rows_m1=3, words 0x44332211+n, in_valid held high -> four writes with a=0..3 and d=word, then done 1 cycle after the last write.
REQ-038 SHALL cover HALF mode: current_state=1, rows_m1=1, words 0xDDCCBBAA and 0x44332211 -> writes (0,0xBBAA), (1,0xDDCC), (2,0x2211), (3,0x4433), then done.
REQ-039 SHALL cover BYTE mode: current_state=2, poolingen_op=0, rows_m1=0, word 0x04030201 -> writes a=0..3 with d=1,2,3,4; without the macro, err=1 with zero writes.
REQ-040 SHALL cover backpressure: in_valid low for 5 cycles between words -> we=0 during the gap, address sequence unchanged, no duplicated or dropped writes.
REQ-041 SHALL cover reset mid-load: rst_n low during HALF row 1 -> all outputs 0 the same cycle; a new start after release begins at a=0.
REQ-042 SHALL cover start in S_WRITE and toggling poolingen_op mid-load -> no effect on the sequence, and exactly one done.
